ctrl_word_exec: RTL and testbench
=================================

// Module: ctrl_word_exec
// PURPOSE
//  Responder for the control-unit sequencer. Accepts one 10-bit control word per step via a valid/ready handshake.
//  Decodes each word into one-cycle datapath strobes, bus select and ALU op, and runs a memory request/ack phase when needed.
//  Returns a done pulse per word. Sits between the control FSM and the datapath/memory in the processor.
// PARAMETERS
//  MEM_TIMEOUT  16  max cycles in MEM_WAIT without mem_ack before abort (>=1)
//  CNT_W        16  width of executed-word counter
// PORTS
//  clk          in   1      system clock, all logic on posedge
//  rst          in   1      synchronous active-high reset
//  ctrl_word    in   10     control word: [9]mem_rd [8]mem_wr [7]ir_ld [6]ac_ld [5]pc_inc [4]ar_ld [3:2]bus_sel [1:0]alu_op
//  ctrl_valid   in   1      ctrl_word valid
//  ctrl_ready   out  1      block can accept a word
//  ir_ld        out  1      IR load strobe
//  ac_ld        out  1      AC load strobe
//  pc_inc       out  1      PC increment strobe
//  ar_ld        out  1      AR load strobe
//  bus_sel      out  2      bus source select, held from ISSUE until next accepted word
//  alu_op       out  2      ALU op, held like bus_sel
//  mem_req      out  1      memory request, held high in MEM_WAIT
//  mem_we       out  1      1 = write, 0 = read; valid while mem_req
//  mem_ack      in   1      memory completion, sampled only in MEM_WAIT
//  done         out  1      one-cycle pulse: word finished
//  err_illegal  out  1      sticky: word with mem_rd and mem_wr both set
//  err_timeout  out  1      sticky: memory phase timed out
//  exec_count   out  CNT_W  number of words completed (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state IDLE. All strobes, mem_req, mem_we, done, err_*, bus_sel, alu_op and exec_count = 0. ctrl_ready = 0 while rst is high.
//  ctrl_ready = (state==IDLE) & ~rst. Accept on ctrl_valid & ctrl_ready; latch the word.
//  FSM states: IDLE -> ISSUE -> (MEM_WAIT) -> DONE -> IDLE.
//  IDLE: wait for accept. Outputs idle (strobes, mem_req, done = 0).
//  ISSUE (1 cycle): ir_ld/ac_ld/pc_inc/ar_ld = latched bits for exactly this cycle. bus_sel and alu_op update.
//   Exit to MEM_WAIT if mem_rd^mem_wr, otherwise to DONE.
//  MEM_WAIT: mem_req=1, mem_we=mem_wr. The wait counter starts at 0 and increments each cycle.
//   mem_ack=1 -> DONE.
//   Counter reaches MEM_TIMEOUT-1 with no ack -> set err_timeout, go to DONE.
//   Ack and timeout in the same cycle -> ack wins, no error.
//  DONE (1 cycle): done=1, exec_count+1 (wraps at 2^CNT_W-1 -> 0), then IDLE.
//  Latency: non-memory word accepted at edge T -> strobes in cycle T+1, done in T+2, ready again in T+3.
//  All-zero word: NOP. Handshake and done still occur; no strobes.
//  Illegal word (mem_rd & mem_wr): no strobes in ISSUE, no memory phase, err_illegal=1, still done and counted.
//  mem_ack outside MEM_WAIT is ignored. ctrl_valid while not ready is ignored; the word is not queued.
//  err_* clear only on rst. Reset in any state aborts: mem_req drops on the reset edge and no done is issued.
// CONFIGURATION
//  CTRL_EXEC_COUNT_EN defined: exec_count implemented as above.
//  Not defined: no counter logic, exec_count tied to 0. Port list unchanged.
// TESTING
//  1 Reset: hold rst 3 cycles mid-MEM_WAIT -> mem_req=0, done=0, err_*=0, ctrl_ready=0 during rst, =1 the cycle after.
//  2 Word 10'b0000010000 valid at T -> ar_ld=1 only in T+1, done at T+2, ready at T+3, exec_count=1.
//  3 Word 10'b1010000110 (rd,ir_ld,bus=01,alu=10) with mem_ack after 3 cycles
//    -> ir_ld 1 cycle; mem_req high 3 cycles with mem_we=0; done the cycle after ack; bus_sel=01 and alu_op=10 held.
//  4 Write word 10'b0100001000 with no ack -> mem_req high 16 cycles, err_timeout=1, done pulses, ready returns.
//  5 Word 10'b1100000000 -> no strobes, no mem_req, err_illegal=1 sticky across later legal words.
//  6 Back-to-back valid words with ack and timeout in the same cycle -> no error.
//    ctrl_valid held during busy accepts nothing extra. Build with and without CTRL_EXEC_COUNT_EN.
//    Count is preset to 2^CNT_W-1; the next done wraps it to 0.

Source files
------------

// File: rtl/ctrl_word_exec.sv
// Control-word executor: takes one control word per handshake, issues one-cycle datapath strobes,
// runs an optional memory request/ack phase, then pulses done. The word counter exists only with CTRL_EXEC_COUNT_EN.
module ctrl_word_exec #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [9:0]       ctrl_word,
  input  logic             ctrl_valid,
  output logic             ctrl_ready,
  output logic             ir_ld,
  output logic             ac_ld,
  output logic             pc_inc,
  output logic             ar_ld,
  output logic [1:0]       bus_sel,
  output logic [1:0]       alu_op,
  output logic             mem_req,
  output logic             mem_we,
  input  logic             mem_ack,
  output logic             done,
  output logic             err_illegal,
  output logic             err_timeout,
  output logic [CNT_W-1:0] exec_count
);

  localparam int unsigned TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_MEM   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic          rd_q, rd_d, wr_q, wr_d;
  logic [3:0]    strb_q, strb_d;
  logic [1:0]    bus_q, bus_d, alu_q, alu_d;
  logic          req_q, req_d, we_q, we_d;
  logic          done_q, done_d;
  logic          ill_q, ill_d, to_q, to_d;
  logic [TW-1:0] wcnt_q, wcnt_d;
  logic          accept_c;

  assign ctrl_ready = (state_q == S_IDLE) & ~rst;
  assign accept_c   = ctrl_valid & ctrl_ready;

  // Next state and next registered outputs; outputs are loaded on the edge entering each state.
  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    strb_d  = 4'b0;
    bus_d   = bus_q;
    alu_d   = alu_q;
    req_d   = 1'b0;
    we_d    = 1'b0;
    done_d  = 1'b0;
    ill_d   = ill_q;
    to_d    = to_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          state_d = S_ISSUE;
          rd_d    = ctrl_word[9];
          wr_d    = ctrl_word[8];
          bus_d   = ctrl_word[3:2];
          alu_d   = ctrl_word[1:0];
          if (!(ctrl_word[9] && ctrl_word[8])) strb_d = ctrl_word[7:4];
        end
      end
      S_ISSUE: begin
        wcnt_d = '0;
        if (rd_q ^ wr_q) begin
          state_d = S_MEM;
          req_d   = 1'b1;
          we_d    = wr_q;
        end else begin
          state_d = S_DONE;
          done_d  = 1'b1;
          if (rd_q && wr_q) ill_d = 1'b1;
        end
      end
      S_MEM: begin
        // Ack is checked first so an ack on the last allowed cycle is not a timeout.
        if (mem_ack) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else if (wcnt_q == TW'(MEM_TIMEOUT - 1)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          to_d    = 1'b1;
        end else begin
          wcnt_d = wcnt_q + TW'(1);
          req_d  = 1'b1;
          we_d   = wr_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      strb_q  <= 4'b0;
      bus_q   <= 2'b0;
      alu_q   <= 2'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      ill_q   <= 1'b0;
      to_q    <= 1'b0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      strb_q  <= strb_d;
      bus_q   <= bus_d;
      alu_q   <= alu_d;
      req_q   <= req_d;
      we_q    <= we_d;
      done_q  <= done_d;
      ill_q   <= ill_d;
      to_q    <= to_d;
      wcnt_q  <= wcnt_d;
    end
  end

  assign {ir_ld, ac_ld, pc_inc, ar_ld} = strb_q;
  assign bus_sel     = bus_q;
  assign alu_op      = alu_q;
  assign mem_req     = req_q;
  assign mem_we      = we_q;
  assign done        = done_q;
  assign err_illegal = ill_q;
  assign err_timeout = to_q;

`ifdef CTRL_EXEC_COUNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Counts on the edge that raises done, so the new value appears with the done pulse.
  always_ff @(posedge clk) begin
    if (rst)         cnt_q <= '0;
    else if (done_d) cnt_q <= cnt_q + CNT_W'(1);
  end

  assign exec_count = cnt_q;
`else
  assign exec_count = '0;
`endif

endmodule

// File: tb/tb_ctrl_word_exec.sv
// Directed bench for ctrl_word_exec with an expected-result queue popped at each done pulse.
// Expectations for exec_count follow CTRL_EXEC_COUNT_EN.
module tb_ctrl_word_exec;

  localparam int unsigned MT   = 16;
  localparam int unsigned CW   = 4;
`ifdef CTRL_EXEC_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [9:0]    ctrl_word;
  logic          ctrl_valid;
  logic          ctrl_ready;
  logic          ir_ld, ac_ld, pc_inc, ar_ld;
  logic [1:0]    bus_sel, alu_op;
  logic          mem_req, mem_we, mem_ack;
  logic          done, err_illegal, err_timeout;
  logic [CW-1:0] exec_count;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0]    strb;
    logic [1:0]    bus;
    logic [1:0]    alu;
    int            mc;
    logic          we;
    int            lat;
    logic          ill;
    logic          to;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t          q[$];
  logic          ill_m = 1'b0;
  logic          to_m  = 1'b0;
  logic [CW-1:0] cnt_m = '0;

  ctrl_word_exec #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .ctrl_word(ctrl_word), .ctrl_valid(ctrl_valid), .ctrl_ready(ctrl_ready),
    .ir_ld(ir_ld), .ac_ld(ac_ld), .pc_inc(pc_inc), .ar_ld(ar_ld), .bus_sel(bus_sel), .alu_op(alu_op),
    .mem_req(mem_req), .mem_we(mem_we), .mem_ack(mem_ack), .done(done),
    .err_illegal(err_illegal), .err_timeout(err_timeout), .exec_count(exec_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ack_at: -1 no ack, 0 stray ack during ISSUE only, k>=1 ack in the k-th mem_req cycle.
  task automatic run_word(input string nm, input logic [9:0] w, input int ack_at, input bit hold);
    exp_t e, g;
    bit   is_mem, is_ill, acked, we_bad, strb_bad;
    int   n, lat, mc;
    is_mem = w[9] ^ w[8];
    is_ill = w[9] & w[8];
    acked  = (ack_at >= 1) && (ack_at <= int'(MT));
    e.strb = is_ill ? 4'b0 : w[7:4];
    e.bus  = w[3:2];
    e.alu  = w[1:0];
    e.mc   = !is_mem ? 0 : (acked ? ack_at : int'(MT));
    e.we   = w[8];
    e.lat  = 2 + e.mc;
    if (is_ill) ill_m = 1'b1;
    if (is_mem && !acked) to_m = 1'b1;
    if (CNT_EN) cnt_m = cnt_m + CW'(1);
    e.ill  = ill_m;
    e.to   = to_m;
    e.cnt  = cnt_m;
    q.push_back(e);

    n = 0;
    while (!ctrl_ready && n < 20) begin @(negedge clk); n++; end
    chk({nm, "_ready_in"}, 32'(ctrl_ready), 32'd1);
    ctrl_word  = w;
    ctrl_valid = 1'b1;
    @(negedge clk);
    if (!hold) ctrl_valid = 1'b0;
    chk({nm, "_strobes"}, 32'({ir_ld, ac_ld, pc_inc, ar_ld}), 32'(e.strb));
    chk({nm, "_bus_alu"}, 32'({bus_sel, alu_op}), 32'({e.bus, e.alu}));
    chk({nm, "_busy"}, 32'({ctrl_ready, mem_req, done}), 32'd0);

    lat = 1; mc = 0; we_bad = 0; strb_bad = 0;
    while (!done && lat < 40) begin
      if (mem_req) begin
        mc++;
        if (mem_we !== e.we) we_bad = 1;
        mem_ack = (mc == ack_at);
      end else begin
        mem_ack = (ack_at == 0) && (lat == 1);
      end
      if (lat > 1 && {ir_ld, ac_ld, pc_inc, ar_ld} !== 4'b0) strb_bad = 1;
      if (lat > 1 && {bus_sel, alu_op} !== {e.bus, e.alu}) strb_bad = 1;
      @(negedge clk);
      lat++;
    end
    mem_ack = 1'b0;

    g = q.pop_front();
    chk({nm, "_done"}, 32'(done), 32'd1);
    chk({nm, "_latency"}, 32'(lat), 32'(g.lat));
    chk({nm, "_memreq_cycles"}, 32'(mc), 32'(g.mc));
    chk({nm, "_mem_we"}, 32'(we_bad), 32'd0);
    chk({nm, "_held_outputs"}, 32'(strb_bad), 32'd0);
    chk({nm, "_err"}, 32'({err_illegal, err_timeout}), 32'({g.ill, g.to}));
    chk({nm, "_count"}, 32'(exec_count), 32'(g.cnt));
    @(negedge clk);
    chk({nm, "_done_pulse"}, 32'(done), 32'd0);
    chk({nm, "_ready_back"}, 32'(ctrl_ready), 32'd1);
    if (hold) begin
      ctrl_valid = 1'b0;
      @(negedge clk);
      chk({nm, "_no_extra_accept"}, 32'({ctrl_ready, ir_ld, ac_ld, pc_inc, ar_ld}), 32'b10000);
    end
  endtask

  initial begin
    int n;
    rst = 1'b1; ctrl_word = '0; ctrl_valid = 1'b0; mem_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(ctrl_ready), 32'd0);
    chk("rst_outputs", 32'({ir_ld, ac_ld, pc_inc, ar_ld, bus_sel, alu_op, mem_req, mem_we, done}), 32'd0);
    chk("rst_err_cnt", 32'({err_illegal, err_timeout, exec_count}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_word("pre_ill", 10'b1100000000, -1, 0);

    // Reset in the middle of a memory wait
    ctrl_word = 10'b1000000000; ctrl_valid = 1'b1;
    @(negedge clk);
    ctrl_valid = 1'b0;
    n = 0;
    while (!mem_req && n < 10) begin @(negedge clk); n++; end
    chk("midmem_req", 32'(mem_req), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midrst_state", 32'({ctrl_ready, mem_req, done, err_illegal, err_timeout, exec_count}), 32'd0);
    end
    rst = 1'b0;
    ill_m = 1'b0; to_m = 1'b0; cnt_m = '0;
    @(negedge clk);
    chk("post_rst_ready", 32'(ctrl_ready), 32'd1);

    run_word("ar_ld",     10'b0000010000, -1, 0);
    run_word("rd_ack3",   10'b1010000110,  3, 0);
    run_word("hold_ir",   10'b0010000001, -1, 1);
    run_word("ack_last",  10'b1000000011, int'(MT), 0);
    run_word("wr_ack1",   10'b0100001101,  1, 0);
    run_word("nop",       10'b0000000000, -1, 0);
    run_word("wr_to",     10'b0100001000,  0, 0);
    run_word("illegal",   10'b1100000000, -1, 0);
    run_word("after_ill", 10'b0001001110, -1, 0);

    for (int i = 0; i < 20 && CNT_EN && cnt_m != {CW{1'b1}}; i++)
      run_word("fill", 10'b0000100000, -1, 0);
    run_word("wrap", 10'b0000000000, -1, 0);
    chk("wrap_zero", 32'(exec_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
